// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART for the peripheral bus: TXD/RXD/CON registers,
// TX and RX FIFOs, serial shifters and registered RX/TX interrupt requests.
//
//   state   | meaning (shared by TX and RX FSMs)
//   S_IDLE  | line idle; TX waits for FIFO data, RX waits for a falling edge
//   S_START | start bit (TX drives 0 / RX checks mid-bit low)
//   S_DATA  | 8 data bits, LSB first
//   S_STOP  | stop bit (TX drives 1 / RX checks high, then pushes)
module uart_mmio #(
  parameter int CLK_DIV    = 10417,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        RX,
  output logic        TX,
  output logic [1:0]  irqout
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_END  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV / 2 - 1);
  localparam logic [PW:0]   DEPTH    = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic sel_txd, sel_rxd, sel_con, con_wr;
  assign sel_txd = (addr == 32'h4000_0018);
  assign sel_rxd = (addr == 32'h4000_001C);
  assign sel_con = (addr == 32'h4000_0020);
  assign con_wr  = wr & sel_con;

  logic unused_bits;
  assign unused_bits = &{1'b0, wdata[31:8]};

  // TX FIFO
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wp, tx_rp;
  logic [PW:0]   tx_cnt;
  logic          tx_full, tx_empty, tx_push, tx_pop, tx_drop;
  state_t        tx_state, tx_state_n;
  logic [CW-1:0] tx_baud, tx_baud_n;
  logic [2:0]    tx_bit, tx_bit_n;
  logic [7:0]    tx_shift, tx_shift_n;

  assign tx_full  = (tx_cnt == DEPTH);
  assign tx_empty = (tx_cnt == '0);
  assign tx_push  = wr & sel_txd & ~tx_full;
  assign tx_drop  = wr & sel_txd & tx_full;
  assign tx_pop   = (tx_state == S_IDLE) & ~tx_empty;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= wdata[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + PW'(1);
      if (tx_pop)  tx_rp <= tx_rp + PW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + (PW+1)'(1);
        2'b01:   tx_cnt <= tx_cnt - (PW+1)'(1);
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= S_IDLE;
      tx_baud  <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      tx_state <= tx_state_n;
      tx_baud  <= tx_baud_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_baud_n  = tx_baud + CW'(1);
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    case (tx_state)
      S_IDLE: begin
        tx_baud_n = '0;
        if (!tx_empty) begin
          tx_state_n = S_START;
          tx_shift_n = tx_mem[tx_rp];
        end
      end
      S_START: if (tx_baud == BIT_END) begin
        tx_state_n = S_DATA;
        tx_baud_n  = '0;
        tx_bit_n   = '0;
      end
      S_DATA: if (tx_baud == BIT_END) begin
        tx_baud_n  = '0;
        tx_shift_n = {1'b0, tx_shift[7:1]};
        tx_bit_n   = tx_bit + 3'd1;
        if (tx_bit == 3'd7) tx_state_n = S_STOP;
      end
      S_STOP: if (tx_baud == BIT_END) begin
        tx_state_n = S_IDLE;
        tx_baud_n  = '0;
      end
      default: tx_state_n = S_IDLE;
    endcase
  end

  assign TX = (tx_state == S_START) ? 1'b0 :
              (tx_state == S_DATA)  ? tx_shift[0] : 1'b1;

  // RX synchronizer plus edge-detect delay; all idle high
  logic rx_s1, rx_s2, rx_d;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= RX;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [PW-1:0] rx_wp, rx_rp;
  logic [PW:0]   rx_cnt;
  logic          rx_full, rx_empty, rx_push, rx_pop, rx_ovr_set, fe_set, stop_tick;
  state_t        rx_state, rx_state_n;
  logic [CW-1:0] rx_baud, rx_baud_n;
  logic [2:0]    rx_bit, rx_bit_n;
  logic [7:0]    rx_shift, rx_shift_n;

  assign rx_full    = (rx_cnt == DEPTH);
  assign rx_empty   = (rx_cnt == '0);
  assign stop_tick  = (rx_state == S_STOP) & (rx_baud == BIT_END);
  assign rx_push    = stop_tick & rx_s2 & ~rx_full;
  assign rx_ovr_set = stop_tick & rx_s2 & rx_full;
  assign fe_set     = stop_tick & ~rx_s2;
  assign rx_pop     = rd & sel_rxd & ~rx_empty;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= rx_shift;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + PW'(1);
      if (rx_pop)  rx_rp <= rx_rp + PW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + (PW+1)'(1);
        2'b01:   rx_cnt <= rx_cnt - (PW+1)'(1);
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state <= S_IDLE;
      rx_baud  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_n;
      rx_baud  <= rx_baud_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_baud_n  = rx_baud + CW'(1);
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    case (rx_state)
      S_IDLE: begin
        rx_baud_n = '0;
        if (rx_d && !rx_s2) rx_state_n = S_START;
      end
      // half-bit wait lands the later samples mid-bit
      S_START: if (rx_baud == HALF_END) begin
        rx_baud_n  = '0;
        rx_bit_n   = '0;
        rx_state_n = rx_s2 ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_baud == BIT_END) begin
        rx_baud_n  = '0;
        rx_shift_n = {rx_s2, rx_shift[7:1]};
        rx_bit_n   = rx_bit + 3'd1;
        if (rx_bit == 3'd7) rx_state_n = S_STOP;
      end
      S_STOP: if (rx_baud == BIT_END) begin
        rx_baud_n  = '0;
        rx_state_n = S_IDLE;
      end
      default: rx_state_n = S_IDLE;
    endcase
  end

  // CON: enables, sticky W1C flags (a hardware set beats a same-edge clear)
  logic tx_ie, rx_ie, rx_ovr, tx_ovf, frame_err, tx_busy;
  assign tx_busy = (tx_state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_ie     <= 1'b0;
      rx_ie     <= 1'b0;
      rx_ovr    <= 1'b0;
      tx_ovf    <= 1'b0;
      frame_err <= 1'b0;
      irqout    <= 2'b00;
    end else begin
      if (con_wr) {rx_ie, tx_ie} <= wdata[1:0];
      rx_ovr    <= (rx_ovr    & ~(con_wr & wdata[5])) | rx_ovr_set;
      tx_ovf    <= (tx_ovf    & ~(con_wr & wdata[6])) | tx_drop;
      frame_err <= (frame_err & ~(con_wr & wdata[7])) | fe_set;
      irqout    <= {tx_ie & tx_empty & ~tx_busy, rx_ie & ~rx_empty};
    end
  end

  always_comb begin
    rdata = '0;
    if (rd) begin
      if (sel_rxd && !rx_empty)
        rdata = {24'b0, rx_mem[rx_rp]};
      else if (sel_con)
        rdata = {24'b0, frame_err, tx_ovf, rx_ovr, tx_busy, tx_full, ~rx_empty, rx_ie, tx_ie};
    end
  end

endmodule

// File: doc/uart_mmio.md
Name: uart_mmio

Overview:
- Memory-mapped UART serving the pipeline's MEM stage: byte transmit, byte receive, status and interrupt requests.
- Sits on the peripheral bus (rd, wr, addr, wdata, rdata) beside the timer/LED/digit peripherals.
- Drives the serial TX pin, samples RX, and raises a 2-bit irqout that the CPU registers into its IRQ inputs.
- 8N1 framing, LSB first, with a TX FIFO and an RX FIFO.

Parameters:
- CLK_DIV, 10417: clock cycles per bit (100 MHz / 9600 baud); at least 4.
- FIFO_DEPTH, 4: entries per FIFO; power of two, at least 2.

Ports:
- clk  in  1  system clock; all state is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- rd  in  1  bus read strobe (MEM stage).
- wr  in  1  bus write strobe (MEM stage).
- addr  in  32  bus byte address.
- wdata  in  32  bus write data.
- rdata  out  32  bus read data; combinational.
- RX  in  1  serial input; asynchronous, idle high.
- TX  out  1  serial output; idle high.
- irqout  out  2  registered interrupt requests: [0] RX, [1] TX.

Behaviour:
- Register map (word addresses; any other address: reads return 0, writes ignored):
  - 0x4000_0018 TXD: a write pushes wdata[7:0]; reads return 0.
  - 0x4000_001C RXD: a read returns {24'b0, head byte} and pops.
  - 0x4000_0020 CON, bits:
    - [0] tx_irq_en, [1] rx_irq_en: R/W.
    - [2] rx_not_empty, [3] tx_full, [4] tx_busy: read-only.
    - [5] rx_overrun, [6] tx_overflow, [7] frame_error: sticky, write-1-to-clear.
    - [31:8]: read 0.
- Read timing:
  - rdata is valid in the same cycle as rd. It is 0 when rd=0.
  - An RXD pop takes effect at the clock edge that ends the rd cycle.
  - A read of an empty RXD returns 0 and does not pop.
- TXD write when the TX FIFO is full: byte dropped, tx_overflow set.
- W1C on the same edge as a hardware set: the set wins.
- rd and wr asserted together: both are honoured independently.
- Reset values: TX=1, irqout=0, both FIFOs empty, all CON bits 0, both FSMs IDLE, bit counters 0.
- Reset mid-frame aborts the frame immediately and TX returns high.
- RX synchronizer: 2 flip-flops on RX, plus one delay flip-flop for edge detection.
- RX FSM:
  - IDLE: a synchronized falling edge goes to START with the counter cleared.
  - START: wait CLK_DIV/2 (integer) cycles, then sample. Low goes to DATA; high is a false start and returns to IDLE.
  - DATA: sample every CLK_DIV cycles, shifting in LSB first. After the 8th sample go to STOP.
  - STOP: sample after CLK_DIV cycles.
    - Low: set frame_error, discard the byte.
    - High: push the byte. If the RX FIFO is full, drop the byte and set rx_overrun.
    - Either way return to IDLE. A new start edge is accepted from the next cycle.
  - A push and an RXD pop on the same edge both take effect; occupancy is unchanged.
- TX FSM:
  - IDLE: if the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: TX=0 for CLK_DIV cycles.
  - DATA: 8 bits, LSB first, CLK_DIV cycles each.
  - STOP: TX=1 for CLK_DIV cycles, then IDLE.
  - Back-to-back bytes: the next start bit begins one cycle after STOP ends. Frame length is 10*CLK_DIV+1 cycles except for the first byte.
  - A pop and a TXD push on the same edge both take effect. A push to a full FIFO is dropped even if a pop occurs on that edge.
  - tx_busy = (state != IDLE).
- Write into an empty FIFO while TX is IDLE: TX goes low 2 cycles after the write edge (push edge, then pop/load edge).
- FIFOs: circular, pointer wrap at FIFO_DEPTH, occupancy counter 0..FIFO_DEPTH. tx_full = (TX count == FIFO_DEPTH).
- irqout is registered every cycle:
  - irqout[0] = rx_irq_en & rx_not_empty.
  - irqout[1] = tx_irq_en & TX FIFO empty & !tx_busy.
- Baud counters: width is clog2(CLK_DIV). Each counter restarts at 0 on every state entry.

Test Plan:
- CLK_DIV=16. Write TXD=0x55 -> TX low 2 cycles after the write. Bits 1,0,1,0,1,0,1,0 follow, 16 cycles each, then stop high. tx_busy=1 throughout the frame.
- Drive an RX frame of 0xA3 at 16 cycles/bit -> CON[2]=1 after the stop sample. RXD read returns 0x000000A3, then CON[2]=0. A second RXD read returns 0.
- Write 5 bytes to TXD back-to-back with FIFO_DEPTH=4 and TX idle -> 5 frames transmitted, tx_overflow=0, since the first byte pops on the edge after its write. Then fill the FIFO while busy (4 writes) and write a 6th byte -> tx_overflow=1 and that byte is never sent. Write CON=0x40 -> bit [6] clears.
- Send 5 RX frames with no reads -> the first 4 read back in order, rx_overrun=1. A frame whose stop bit is 0 -> frame_error=1 and nothing is pushed.
- A 4-cycle low glitch on idle RX -> false start: no push, FSM back in IDLE.
- Set CON=0x3 -> irqout[1]=1 while idle and empty. After an RX frame is received, irqout[0]=1 one cycle after rx_not_empty rises. Assert reset mid-TX-frame -> TX=1 and irqout=0 immediately.
